rx_bg_top: RTL and testbench

RX_BG_TOP -- requirements
Module: rx_bg_top

---
 rtl/rx_bg_top.sv | 137 +++++++++++++
 tb/tb_rx_bg_top.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rx_bg_top.sv
// Oversampling UART receiver: 2-flop synchronizer, baud tick generator and start/data/stop FSM.
// Define RX_FRAME_ERR_EN to drop frames with a bad stop bit and pulse o_frame_err instead.
module rx_bg_top #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int NB_STATE = 2,
    parameter int BAUD_DIV = 163
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [NB_STATE-1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_sync;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [3:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            s              <= '0;
            n              <= '0;
            b              <= '0;
            o_data         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                // Half a bit in: a line that has gone high again was only a glitch.
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            s <= '0;
                            if (!rx_sync) begin
                                state <= DATA;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s <= '0;
                            b <= {rx_sync, b[DBIT-1:1]};
                            if (n == NW'(DBIT - 1)) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == 4'(SB_TICK - 1)) begin
                            state <= IDLE;
                            s     <= '0;
`ifdef RX_FRAME_ERR_EN
                            if (rx_sync) begin
                                o_data         <= b;
                                o_rx_done_tick <= 1'b1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
`else
                            o_data         <= b;
                            o_rx_done_tick <= 1'b1;
`endif
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bg_top.sv
// Directed bench for rx_bg_top with a short baud divider so each bit lasts 64 clocks.
module tb_rx_bg_top;

    localparam int BAUD_DIV = 4;
    localparam int BIT      = 16 * BAUD_DIV;

    logic       i_clock;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done_tick;
    logic       o_frame_err;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;
    int run_len;
    int max_run;

    rx_bg_top #(
        .DBIT    (8),
        .SB_TICK (16),
        .NB_STATE(2),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_rx_done_tick(o_rx_done_tick),
        .o_frame_err   (o_frame_err)
    );

    initial begin
        i_clock = 1'b0;
        forever #10 i_clock = ~i_clock;
    end

    // Pulse counters and widest done pulse, sampled away from the active edge.
    initial begin
        done_cnt = 0;
        err_cnt  = 0;
        run_len  = 0;
        max_run  = 0;
        forever begin
            @(negedge i_clock);
            if (o_frame_err) err_cnt++;
            if (o_rx_done_tick) begin
                done_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic val, input int cycles);
        i_rx = val;
        repeat (cycles) @(negedge i_clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_cycles);
        apply_stimulus(1'b0, BIT);
        for (int i = 0; i < 8; i++) apply_stimulus(d[i], BIT);
        apply_stimulus(stop_val, stop_cycles);
        i_rx = 1'b1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        #1000;
        @(negedge i_clock);
        check_output("reset_data", 32'(o_data), 32'h00);
        check_output("reset_done", 32'(o_rx_done_tick), 32'h0);
        check_output("reset_err", 32'(o_frame_err), 32'h0);
        i_reset = 1'b0;
        apply_stimulus(1'b1, BIT);

        $display("[TB] frame 0xAA");
        send_frame(8'hAA, 1'b1, BIT);
        apply_stimulus(1'b1, BIT);
        check_output("aa_data", 32'(o_data), 32'hAA);
        check_output("aa_done_cnt", 32'(done_cnt), 32'd1);
        check_output("aa_err_cnt", 32'(err_cnt), 32'd0);

        $display("[TB] back-to-back 0x55 0xF0");
        send_frame(8'h55, 1'b1, BIT);
        check_output("b2b_55_data", 32'(o_data), 32'h55);
        check_output("b2b_55_done_cnt", 32'(done_cnt), 32'd2);
        send_frame(8'hF0, 1'b1, BIT);
        apply_stimulus(1'b1, BIT);
        check_output("b2b_f0_data", 32'(o_data), 32'hF0);
        check_output("b2b_f0_done_cnt", 32'(done_cnt), 32'd3);

        $display("[TB] start glitch");
        apply_stimulus(1'b0, 3 * BAUD_DIV);
        apply_stimulus(1'b1, 2 * BIT);
        check_output("glitch_data", 32'(o_data), 32'hF0);
        check_output("glitch_done_cnt", 32'(done_cnt), 32'd3);
        check_output("glitch_err_cnt", 32'(err_cnt), 32'd0);

        $display("[TB] frame 0x3C with low stop bit");
        send_frame(8'h3C, 1'b0, (3 * BIT) / 4);
        apply_stimulus(1'b1, 3 * BIT);
`ifdef RX_FRAME_ERR_EN
        check_output("stoperr_data", 32'(o_data), 32'hF0);
        check_output("stoperr_done_cnt", 32'(done_cnt), 32'd3);
        check_output("stoperr_err_cnt", 32'(err_cnt), 32'd1);
        begin : pulse_totals
            int exp_done;
            int exp_err;
            exp_done = 3;
            exp_err  = 1;
`else
        check_output("stoplow_data", 32'(o_data), 32'h3C);
        check_output("stoplow_done_cnt", 32'(done_cnt), 32'd4);
        check_output("stoplow_err_cnt", 32'(err_cnt), 32'd0);
        begin : pulse_totals
            int exp_done;
            int exp_err;
            exp_done = 4;
            exp_err  = 0;
`endif

            $display("[TB] reset during data bit 4 of 0xC3");
            apply_stimulus(1'b0, BIT);
            apply_stimulus(1'b1, BIT);
            apply_stimulus(1'b1, BIT);
            apply_stimulus(1'b0, BIT);
            apply_stimulus(1'b0, BIT);
            apply_stimulus(1'b0, BIT / 2);
            i_reset = 1'b1;
            @(negedge i_clock);
            i_reset = 1'b0;
            apply_stimulus(1'b1, 3 * BIT);
            check_output("midreset_data", 32'(o_data), 32'h00);
            check_output("midreset_done_cnt", 32'(done_cnt), 32'(exp_done));
            check_output("midreset_err_cnt", 32'(err_cnt), 32'(exp_err));

            $display("[TB] frame 0x81 after reset");
            send_frame(8'h81, 1'b1, BIT);
            apply_stimulus(1'b1, BIT);
            check_output("post_reset_data", 32'(o_data), 32'h81);
            check_output("post_reset_done_cnt", 32'(done_cnt), 32'(exp_done + 1));
            check_output("post_reset_err_cnt", 32'(err_cnt), 32'(exp_err));
        end

        check_output("done_pulse_width", 32'(max_run), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
